// File: rtl/am9513_bus_master.sv
// am9513_bus_master: host-side bus initiator for the Am9513 timer chip.
// Turns single-word command/data read/write requests into CS_n/CD_n/RD_n/WR_n
// cycles (SETUP, STROBE, RECOVER clocks each) and captures read data.
// Optional macro AM9513_INIT_EN adds a power-up sequencer that programs and
// arms counter 1 with INIT_LOAD before the engine accepts requests.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req, rw, cd, wdata      request (rw 1=read, cd 1=command/status)
//   ready, done, rdata      idle/accepting, completion pulse, read word
//   init_done               power-up sequence finished (tied 1 without option)
//   cs_n, cd_n, rd_n, wr_n  chip control pins
//   d_out, d_oe, d_in       chip data bus (external tristate)
module am9513_bus_master #(
   parameter int unsigned SETUP   = 1,
   parameter int unsigned STROBE  = 3,
   parameter int unsigned RECOVER = 2
`ifdef AM9513_INIT_EN
   , parameter logic [15:0] INIT_LOAD = 16'd1000
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        rw,
   input  logic        cd,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [15:0] rdata,
   output logic        init_done,
   output logic        cs_n,
   output logic        cd_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic [15:0] d_out,
   output logic        d_oe,
   input  logic [15:0] d_in
);

   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RECOVER} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          rw_q;

`ifdef AM9513_INIT_EN
   localparam logic [2:0] INIT_LAST = 3'd5;

   logic [2:0]  init_idx;
   logic [15:0] init_word_c;
   logic        init_cd_c;

   // Fixed programming words for counter 1: reset, point at load reg, load, arm.
   always_comb begin
      init_word_c = 16'h0000;
      init_cd_c   = 1'b1;
      case (init_idx)
         3'd0:    init_word_c = 16'h00FF;
         3'd1:    init_word_c = 16'h0009;
         3'd2:    begin init_word_c = {8'h00, INIT_LOAD[7:0]};  init_cd_c = 1'b0; end
         3'd3:    begin init_word_c = {8'h00, INIT_LOAD[15:8]}; init_cd_c = 1'b0; end
         3'd4:    init_word_c = 16'h0061;
         default: init_word_c = 16'h0000;
      endcase
   end
`else
   assign init_done = 1'b1;
`endif

   // Bus sequencer; every pin is registered from the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         rw_q  <= 1'b0;
         cs_n  <= 1'b1;
         cd_n  <= 1'b1;
         rd_n  <= 1'b1;
         wr_n  <= 1'b1;
         d_oe  <= 1'b0;
         d_out <= '0;
         rdata <= '0;
         done  <= 1'b0;
`ifdef AM9513_INIT_EN
         ready     <= 1'b0;
         init_done <= 1'b0;
         init_idx  <= '0;
`else
         ready <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
`ifdef AM9513_INIT_EN
               if (!init_done) begin
                  rw_q     <= 1'b0;
                  cs_n     <= 1'b0;
                  cd_n     <= init_cd_c;
                  d_oe     <= 1'b1;
                  d_out    <= init_word_c;
                  init_idx <= init_idx + 3'd1;
                  state    <= ST_SETUP;
                  cnt      <= CW'(SETUP - 1);
               end else
`endif
               if (req && ready) begin
                  rw_q  <= rw;
                  cs_n  <= 1'b0;
                  cd_n  <= cd;
                  d_oe  <= ~rw;
                  d_out <= wdata;
                  ready <= 1'b0;
                  state <= ST_SETUP;
                  cnt   <= CW'(SETUP - 1);
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  rd_n  <= ~rw_q;
                  wr_n  <= rw_q;
                  state <= ST_STROBE;
                  cnt   <= CW'(STROBE - 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_STROBE: begin
               if (cnt == '0) begin
                  rd_n  <= 1'b1;
                  wr_n  <= 1'b1;
                  if (rw_q) rdata <= d_in;
                  state <= ST_RECOVER;
                  cnt   <= CW'(RECOVER - 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_RECOVER: begin
               // First recover cycle keeps CS/CD/data for hold time, then release.
               cs_n <= 1'b1;
               cd_n <= 1'b1;
               d_oe <= 1'b0;
               if (cnt == '0) begin
                  state <= ST_IDLE;
`ifdef AM9513_INIT_EN
                  done  <= init_done;
                  ready <= init_done | (init_idx == INIT_LAST);
                  if (init_idx == INIT_LAST) init_done <= 1'b1;
`else
                  done  <= 1'b1;
                  ready <= 1'b1;
`endif
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_am9513_bus_master.sv
// Testbench for am9513_bus_master: timing of single writes/reads, back-to-back
// period, busy-request rejection, async reset, and a word scoreboard fed by a
// pin-level bus monitor. With AM9513_INIT_EN it also checks the init sequence.
module tb_am9513_bus_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic        rw = 1'b0;
   logic        cd = 1'b0;
   logic [15:0] wdata = 16'h0000;
   logic [15:0] rd_val = 16'h0000;
   logic        ready, done, init_done, cs_n, cd_n, rd_n, wr_n, d_oe;
   logic [15:0] rdata, d_out, d_in;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int rd_used = 0;

   logic [17:0] exp_q[$];
   logic [17:0] obs_q[$];
   logic        rd_cd = 1'b0;

   am9513_bus_master dut (
      .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .cd(cd), .wdata(wdata),
      .ready(ready), .done(done), .rdata(rdata), .init_done(init_done),
      .cs_n(cs_n), .cd_n(cd_n), .rd_n(rd_n), .wr_n(wr_n),
      .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chip model drives its read word only while selected and RD_n is low.
   assign d_in = (!cs_n && !rd_n) ? rd_val : 16'h0000;

   // Bus monitor: writes are captured when WR_n rises, reads at done.
   always @(posedge wr_n) if (reset_n) obs_q.push_back({1'b0, cd_n, d_out});
   always @(posedge rd_n) if (reset_n) begin rd_cnt++; rd_cd = cd_n; end
   always @(negedge clk) if (done && rd_cnt != rd_used) begin
      rd_used = rd_cnt;
      obs_q.push_back({1'b1, rd_cd, rdata});
   end

`ifdef AM9513_INIT_EN
   logic        ptr_ld1 = 1'b0;
   logic        hi_byte = 1'b0;
   logic        armed = 1'b0;
   logic [15:0] ld1 = 16'h0000;
   // Minimal Am9513 register model for counter 1 load/arm.
   always @(posedge wr_n) if (reset_n) begin
      if (cd_n) begin
         if (d_out == 16'h00FF) begin armed = 1'b0; ptr_ld1 = 1'b0; end
         else if (d_out == 16'h0009) begin ptr_ld1 = 1'b1; hi_byte = 1'b0; end
         else if (d_out == 16'h0061) armed = 1'b1;
      end else if (ptr_ld1) begin
         if (!hi_byte) ld1[7:0] = d_out[7:0]; else ld1[15:8] = d_out[7:0];
         hi_byte = ~hi_byte;
      end
   end

   task automatic push_init_words();
      exp_q.push_back({1'b0, 1'b1, 16'h00FF});
      exp_q.push_back({1'b0, 1'b1, 16'h0009});
      exp_q.push_back({1'b0, 1'b0, 16'h00E8});
      exp_q.push_back({1'b0, 1'b0, 16'h0003});
      exp_q.push_back({1'b0, 1'b1, 16'h0061});
   endtask
`endif

   // Waits for acceptance, then measures pin activity over the following cycles.
   task automatic run_txn(input logic trw, input logic tcd, input logic [15:0] twd,
                          output int cs_c, output int wr_c, output int rd_c,
                          output int oe_c, output int done_at, output int cd_bad,
                          output logic [15:0] dout_s, output logic [15:0] rdata_s);
      bit acc;
      cs_c = 0; wr_c = 0; rd_c = 0; oe_c = 0; done_at = -1; cd_bad = 0;
      dout_s = 16'h0000; rdata_s = 16'h0000; acc = 1'b0;
      @(negedge clk);
      req = 1'b1; rw = trw; cd = tcd; wdata = twd;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (ready) acc = 1'b1; else @(negedge clk);
      end
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout ready stayed %0b, required 1", ready);
         req = 1'b0;
         return;
      end
      @(posedge clk); #1 req = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!cs_n) begin cs_c++; if (cd_n !== tcd) cd_bad++; end
         if (!wr_n) wr_c++;
         if (!rd_n) rd_c++;
         if (d_oe) begin oe_c++; dout_s = d_out; end
         if (done && done_at < 0) begin done_at = k; rdata_s = rdata; end
      end
   endtask

   task automatic test_reset();
      logic [9:0] got, want;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
`ifdef AM9513_INIT_EN
      want = 10'b1111_0_0_0_0_0_0;
`else
      want = 10'b1111_0_0_1_1_0_0;
`endif
      got = {cs_n, cd_n, rd_n, wr_n, d_oe, done, ready, init_done, |d_out, |rdata};
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL reset_pins got %b required %b", got, want);
      end
      reset_n = 1'b1;
`ifdef AM9513_INIT_EN
      push_init_words();
`endif
      @(negedge clk);
   endtask

`ifdef AM9513_INIT_EN
   task automatic test_init();
      int dn = 0;
      bit fin = 1'b0;
      for (int k = 0; k < 300 && !fin; k++) begin
         @(negedge clk);
         if (done) dn++;
         if (init_done) fin = 1'b1;
      end
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL init_done_timeout got %0b required 1", init_done); end
      n_cmp++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL init_ready got %0b required 1", ready); end
      n_cmp++;
      if (dn !== 0) begin n_err++; $display("FAIL init_done_pulses got %0d required 0", dn); end
      n_cmp++;
      if (armed !== 1'b1 || ld1 !== 16'h03E8) begin
         n_err++;
         $display("FAIL init_ctr1 got armed=%0b load=%h required armed=1 load=03e8", armed, ld1);
      end
   endtask
`endif

   task automatic test_cmd_write();
      int cs_c, wr_c, rd_c, oe_c, done_at, cd_bad;
      logic [15:0] dout_s, rdata_s;
      exp_q.push_back({1'b0, 1'b1, 16'h0061});
      run_txn(1'b0, 1'b1, 16'h0061, cs_c, wr_c, rd_c, oe_c, done_at, cd_bad, dout_s, rdata_s);
      n_cmp++; if (cs_c !== 5) begin n_err++; $display("FAIL wr_cs_low got %0d required 5", cs_c); end
      n_cmp++; if (wr_c !== 3) begin n_err++; $display("FAIL wr_strobe got %0d required 3", wr_c); end
      n_cmp++; if (rd_c !== 0) begin n_err++; $display("FAIL wr_no_rd got %0d required 0", rd_c); end
      n_cmp++; if (oe_c !== 5) begin n_err++; $display("FAIL wr_oe got %0d required 5", oe_c); end
      n_cmp++; if (dout_s !== 16'h0061) begin n_err++; $display("FAIL wr_dout got %h required 0061", dout_s); end
      n_cmp++; if (done_at !== 6) begin n_err++; $display("FAIL wr_done_at got %0d required 6", done_at); end
      n_cmp++; if (cd_bad !== 0) begin n_err++; $display("FAIL wr_cd_n got %0d bad cycles required 0", cd_bad); end
   endtask

   task automatic test_data_read();
      int cs_c, wr_c, rd_c, oe_c, done_at, cd_bad;
      logic [15:0] dout_s, rdata_s;
      rd_val = 16'hBEEF;
      exp_q.push_back({1'b1, 1'b0, 16'hBEEF});
      run_txn(1'b1, 1'b0, 16'h1111, cs_c, wr_c, rd_c, oe_c, done_at, cd_bad, dout_s, rdata_s);
      n_cmp++; if (rd_c !== 3) begin n_err++; $display("FAIL rd_strobe got %0d required 3", rd_c); end
      n_cmp++; if (wr_c !== 0) begin n_err++; $display("FAIL rd_no_wr got %0d required 0", wr_c); end
      n_cmp++; if (oe_c !== 0) begin n_err++; $display("FAIL rd_oe got %0d required 0", oe_c); end
      n_cmp++; if (cs_c !== 5) begin n_err++; $display("FAIL rd_cs_low got %0d required 5", cs_c); end
      n_cmp++; if (cd_bad !== 0) begin n_err++; $display("FAIL rd_cd_n got %0d bad cycles required 0", cd_bad); end
      n_cmp++; if (done_at !== 6) begin n_err++; $display("FAIL rd_done_at got %0d required 6", done_at); end
      n_cmp++; if (rdata_s !== 16'hBEEF) begin n_err++; $display("FAIL rd_data got %h required beef", rdata_s); end
   endtask

   task automatic test_rdata_hold();
      int cs_c, wr_c, rd_c, oe_c, done_at, cd_bad;
      logic [15:0] dout_s, rdata_s;
      rd_val = 16'h1234;
      exp_q.push_back({1'b1, 1'b1, 16'h1234});
      run_txn(1'b1, 1'b1, 16'h0000, cs_c, wr_c, rd_c, oe_c, done_at, cd_bad, dout_s, rdata_s);
      n_cmp++; if (rdata_s !== 16'h1234) begin n_err++; $display("FAIL rd2_data got %h required 1234", rdata_s); end
      rd_val = 16'h7777;
      exp_q.push_back({1'b0, 1'b0, 16'h00AA});
      run_txn(1'b0, 1'b0, 16'h00AA, cs_c, wr_c, rd_c, oe_c, done_at, cd_bad, dout_s, rdata_s);
      n_cmp++; if (rdata_s !== 16'h1234) begin n_err++; $display("FAIL rdata_hold got %h required 1234", rdata_s); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w[3];
      int acc_cyc[3];
      int n_acc = 0, hi_cnt = 0, dn = 0;
      bit fin = 1'b0;
      w[0] = 16'h0101; w[1] = 16'h0202; w[2] = 16'h0303;
      for (int i = 0; i < 3; i++) begin
         acc_cyc[i] = 0;
         exp_q.push_back({1'b0, 1'b1, w[i]});
      end
      @(negedge clk);
      req = 1'b1; rw = 1'b0; cd = 1'b1; wdata = w[0];
      for (int k = 0; k < 80 && !fin; k++) begin
         if (k > 0) @(negedge clk);
         if (done) dn++;
         if (cs_n && n_acc >= 1 && n_acc < 3) hi_cnt++;
         if (ready && req) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            @(posedge clk); #1;
            if (n_acc < 3) wdata = w[n_acc]; else req = 1'b0;
         end
         if (dn >= 3) fin = 1'b1;
      end
      req = 1'b0;
      n_cmp++; if (n_acc !== 3 || !fin) begin n_err++; $display("FAIL b2b_count got %0d accepts %0d dones required 3", n_acc, dn); end
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 7) begin n_err++; $display("FAIL b2b_period1 got %0d required 7", acc_cyc[1] - acc_cyc[0]); end
      n_cmp++; if (acc_cyc[2] - acc_cyc[1] !== 7) begin n_err++; $display("FAIL b2b_period2 got %0d required 7", acc_cyc[2] - acc_cyc[1]); end
      n_cmp++; if (hi_cnt !== 4) begin n_err++; $display("FAIL b2b_cs_gap got %0d required 4", hi_cnt); end
   endtask

   task automatic test_busy_ignore();
      int dn = 0;
      bit acc = 1'b0;
      logic in_strobe = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 16'h5A5A});
      @(negedge clk);
      req = 1'b1; rw = 1'b0; cd = 1'b0; wdata = 16'h5A5A;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (ready) acc = 1'b1; else @(negedge clk);
      end
      @(posedge clk); #1 req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (done) dn++;
         if (k == 2) begin
            in_strobe = ~wr_n;
            req = 1'b1; wdata = 16'hDEAD;
            @(posedge clk); #1 req = 1'b0;
         end
      end
      n_cmp++; if (in_strobe !== 1'b1) begin n_err++; $display("FAIL busy_in_strobe got %0b required 1", in_strobe); end
      n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL busy_done_count got %0d required 1", dn); end
   endtask

   task automatic test_reset_mid();
      bit acc = 1'b0;
      logic [3:0] got;
      @(negedge clk);
      req = 1'b1; rw = 1'b0; cd = 1'b1; wdata = 16'h0F0F;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (ready) acc = 1'b1; else @(negedge clk);
      end
      @(posedge clk); #1 req = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_pre got wr_n=%0b required 0", wr_n); end
      #2 reset_n = 1'b0;
      #1 got = {cs_n, wr_n, rd_n, d_oe};
      n_cmp++; if (got !== 4'b1110) begin n_err++; $display("FAIL rst_mid_async got %b required 1110", got); end
`ifdef AM9513_INIT_EN
      push_init_words();
`endif
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL rst_mid_rdata got %h required 0000", rdata); end
`ifdef AM9513_INIT_EN
      for (int k = 0; k < 300 && !ready; k++) @(negedge clk);
`endif
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %0b required 1", ready); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_scoreboard();
      logic [17:0] e, o;
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_err++;
         $display("FAIL sb_count got %0d words required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL sb_word got rw=%0b cd=%0b d=%h required rw=%0b cd=%0b d=%h",
                     o[17], o[16], o[15:0], e[17], e[16], e[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef AM9513_INIT_EN
      test_init();
`endif
      test_cmd_write();
      test_data_read();
      test_rdata_hold();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_scoreboard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
